// File: rtl/reg7_deserializer.sv
// Framed LSB-first serial receiver assembling WIDTH-bit words into a valid/ready holding register.
// Optional even-parity bit between data and stop is built when REG7_PARITY_EN is defined.
module reg7_deserializer #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_en,
    input  logic             sdi,
    input  logic             word_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             busy,
    output logic             framing_err,
    output logic             parity_err,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
`ifdef REG7_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic [WIDTH-1:0] word_nx;
    logic             valid_nx;
    logic             ferr_nx, ovr_nx;
    logic             good;
`ifdef REG7_PARITY_EN
    logic             par_bit, par_nx;
    logic             perr_nx;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            shreg       <= '0;
            word_out    <= '0;
            word_valid  <= 1'b0;
            busy        <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            shreg       <= shreg_nx;
            word_out    <= word_nx;
            word_valid  <= valid_nx;
            busy        <= (state_nx != IDLE);
            framing_err <= ferr_nx;
            overrun     <= ovr_nx;
        end
    end

`ifdef REG7_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            par_bit    <= par_nx;
            parity_err <= perr_nx;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        shreg_nx = shreg;
        word_nx  = word_out;
        valid_nx = word_valid;
        ferr_nx  = 1'b0;
        ovr_nx   = 1'b0;
        good     = 1'b0;
`ifdef REG7_PARITY_EN
        par_nx   = par_bit;
        perr_nx  = 1'b0;
`endif

        if (word_valid && word_ready)
            valid_nx = 1'b0;

        if (bit_en) begin
            case (state)
                IDLE: begin
                    if (!sdi) begin
                        state_nx = DATA;
                        cnt_nx   = '0;
                    end
                end
                DATA: begin
                    shreg_nx = {sdi, shreg[WIDTH-1:1]};
                    if (cnt == CW'(WIDTH-1)) begin
                        cnt_nx = '0;
`ifdef REG7_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = STOP;
`endif
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
`ifdef REG7_PARITY_EN
                PARITY: begin
                    par_nx   = sdi;
                    state_nx = STOP;
                end
`endif
                STOP: begin
                    state_nx = IDLE;
                    if (!sdi)
                        ferr_nx = 1'b1;
`ifdef REG7_PARITY_EN
                    else if ((^shreg) ^ par_bit)
                        perr_nx = 1'b1;
`endif
                    else
                        good = 1'b1;
                end
                default: state_nx = IDLE;
            endcase
        end

        // A same-edge acceptance frees the holding register for the new word.
        if (good) begin
            if (!word_valid || word_ready) begin
                word_nx  = shreg;
                valid_nx = 1'b1;
            end else begin
                ovr_nx = 1'b1;
            end
        end
    end

endmodule
